// File: rtl/acc_dequant_expand.sv
// INT16 -> INT32 stream rescaler: multiply, round-shift, saturate.
// Three-stage pipeline with a global stall and a per-pixel channel counter.
module acc_dequant_expand #(
    parameter int NUM_CHANNELS = 64,
    parameter int IN_WIDTH     = 16,
    parameter int OUT_WIDTH    = 32,
    parameter int SHIFT        = 8
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    input  logic                        in_last,
    input  logic [31:0]                 multiplier,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_last,
    output logic                        err_last_misalign
);

    localparam int PW = IN_WIDTH + 33;
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CHANNELS - 1);
    localparam logic signed [PW-1:0] RND_BIAS = PW'(64'd1 << (SHIFT - 1));
    localparam logic signed [PW-1:0] SAT_MAX =
        {{(PW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    logic                        w_en;
    logic                        w_accept;
    logic                        w_ch_wrap;
    logic                        w_beat_last;
    logic signed [PW-1:0]        w_prod;
    logic signed [PW-1:0]        w_rnd;
    logic signed [OUT_WIDTH-1:0] w_sat;

    logic                        r_s1_vld;
    logic                        r_s1_last;
    logic signed [PW-1:0]        r_s1_prod;
    logic                        r_s2_vld;
    logic                        r_s2_last;
    logic signed [PW-1:0]        r_s2_rnd;
    logic                        r_out_vld;
    logic                        r_out_last;
    logic signed [OUT_WIDTH-1:0] r_out_data;
    logic [CW-1:0]               r_ch_cnt;
    logic                        r_err;

    assign w_en        = !r_out_vld || out_ready;
    assign w_accept    = in_valid && w_en;
    assign w_ch_wrap   = (r_ch_cnt == LAST_CH);
    assign w_beat_last = in_last && w_ch_wrap;

    // Zero-extend the multiplier so it is treated as unsigned in a signed product.
    assign w_prod = $signed(in_data) * $signed({1'b0, multiplier});
    assign w_rnd  = (r_s1_prod + RND_BIAS) >>> SHIFT;

    always_comb begin
        w_sat = r_s2_rnd[OUT_WIDTH-1:0];
        if (r_s2_rnd > SAT_MAX) begin
            w_sat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (r_s2_rnd < SAT_MIN) begin
            w_sat = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_s1_vld   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_prod  <= '0;
            r_s2_vld   <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_rnd   <= '0;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
            r_out_data <= '0;
        end else if (w_en) begin
            r_s1_vld   <= w_accept;
            r_s1_last  <= w_beat_last;
            r_s1_prod  <= w_prod;
            r_s2_vld   <= r_s1_vld;
            r_s2_last  <= r_s1_last;
            r_s2_rnd   <= w_rnd;
            r_out_vld  <= r_s2_vld;
            r_out_last <= r_s2_last;
            r_out_data <= w_sat;
        end
    end

    // A misplaced in_last flags an error but never resyncs the counter.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_ch_cnt <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_ch_cnt <= w_ch_wrap ? '0 : r_ch_cnt + CW'(1);
            if (in_last && !w_ch_wrap) begin
                r_err <= 1'b1;
            end
        end
    end

    assign in_ready          = w_en;
    assign out_valid         = r_out_vld;
    assign out_last          = r_out_last;
    assign out_data          = r_out_data;
    assign err_last_misalign = r_err;

endmodule

// File: tb/tb_acc_dequant_expand.sv
// Directed bench for acc_dequant_expand: arithmetic, latency, stall,
// channel/last tracking and mid-stream reset.
module tb_acc_dequant_expand;

    logic               aclk;
    logic               areset;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               in_last;
    logic [31:0]        multiplier;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic               out_last;
    logic               err_last_misalign;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] cap_data [0:127];
    logic        cap_last [0:127];
    int          cap_n;

    acc_dequant_expand dut (
        .aclk              (aclk),
        .areset            (areset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_last           (in_last),
        .multiplier        (multiplier),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_last          (out_last),
        .err_last_misalign (err_last_misalign)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic do_reset();
        areset   = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        multiplier = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    // Sends one beat and waits for it; lat counts edges including the accept edge.
    task automatic run_beat(input logic [15:0] d, input logic [31:0] m,
                            output logic [31:0] res, output int lat);
        in_valid   = 1'b1;
        in_data    = d;
        multiplier = m;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        @(posedge aclk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge aclk);
            #1 lat++;
        end
        res = out_data;
        @(posedge aclk);
        #1;
    endtask

    // Streams beats with data=index, mult=256 (identity), always ready.
    task automatic drive_stream(input int n, input int last_idx);
        out_ready = 1'b1;
        cap_n = 0;
        for (int c = 0; c < n + 6; c++) begin
            if (c < n) begin
                in_valid   = 1'b1;
                in_data    = 16'(c);
                multiplier = 32'd256;
                in_last    = (c == last_idx);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(posedge aclk);
            #1;
            if (out_valid && cap_n < 128) begin
                cap_data[cap_n] = out_data;
                cap_last[cap_n] = out_last;
                cap_n++;
            end
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        multiplier = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'd0)
            $display("FAIL reset_outputs: got v=%b l=%b d=%h want 0 0 0",
                     out_valid, out_last, out_data);
        else n_pass++;
        n_total++;
        if (err_last_misalign !== 1'b0)
            $display("FAIL reset_err: got %b want 0", err_last_misalign);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        areset = 1'b0;
    endtask

    task automatic test_latency();
        logic [31:0] r;
        int lat;
        run_beat(16'sd100, 32'd768, r, lat);
        n_total++;
        if (r !== 32'd300) $display("FAIL basic_300: got %0d want 300", $signed(r));
        else n_pass++;
        n_total++;
        if (lat !== 3) $display("FAIL latency: got %0d want 3", lat);
        else n_pass++;
    endtask

    task automatic test_rounding();
        logic [31:0] r;
        int lat;
        run_beat(16'sd1, 32'd128, r, lat);
        n_total++;
        if (r !== 32'd1) $display("FAIL rnd_1_128: got %h want 00000001", r);
        else n_pass++;
        run_beat(-16'sd1, 32'd128, r, lat);
        n_total++;
        if (r !== 32'd0) $display("FAIL rnd_m1_128: got %h want 00000000", r);
        else n_pass++;
        run_beat(-16'sd1, 32'd384, r, lat);
        n_total++;
        if (r !== 32'hFFFFFFFF) $display("FAIL rnd_m1_384: got %h want ffffffff", r);
        else n_pass++;
        run_beat(-16'sd5, 32'd1000, r, lat);
        n_total++;
        if (r !== 32'hFFFFFFEC) $display("FAIL rnd_m5_1000: got %h want ffffffec", r);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [31:0] r;
        int lat;
        run_beat(16'sd32767, 32'hFFFFFFFF, r, lat);
        n_total++;
        if (r !== 32'h7FFFFFFF) $display("FAIL sat_pos: got %h want 7fffffff", r);
        else n_pass++;
        run_beat(16'h8000, 32'hFFFFFFFF, r, lat);
        n_total++;
        if (r !== 32'h80000000) $display("FAIL sat_neg: got %h want 80000000", r);
        else n_pass++;
        run_beat(16'sd1234, 32'd0, r, lat);
        n_total++;
        if (r !== 32'd0) $display("FAIL mult_zero: got %h want 00000000", r);
        else n_pass++;
        run_beat(16'sd32767, 32'd65536, r, lat);
        n_total++;
        if (r !== 32'd8388352) $display("FAIL no_sat_big: got %0d want 8388352", r);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int rcvd = 0;
        int d;
        int k;
        logic acc;
        logic prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic prev_last = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 2000 && rcvd < 128; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 128) begin
                in_valid   = 1'b1;
                in_data    = 16'(sent * 100 - 6000);
                multiplier = 32'(256 * (sent % 4 + 1));
                in_last    = (sent == 127);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            #1;
            n_total++;
            if (in_ready !== (!out_valid || out_ready))
                $display("FAIL in_ready_rule: got %b want %b", in_ready,
                         !out_valid || out_ready);
            else n_pass++;
            if (prev_stall) begin
                n_total++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last)
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want 1 %h %b",
                             out_valid, out_data, out_last, prev_data, prev_last);
                else n_pass++;
            end
            if (out_valid && out_ready) begin
                d = rcvd * 100 - 6000;
                k = rcvd % 4 + 1;
                n_total++;
                if (out_data !== 32'(d * k))
                    $display("FAIL stream_data[%0d]: got %0d want %0d", rcvd,
                             $signed(out_data), d * k);
                else n_pass++;
                n_total++;
                if (out_last !== (rcvd == 127))
                    $display("FAIL stream_last[%0d]: got %b want %b", rcvd,
                             out_last, rcvd == 127);
                else n_pass++;
                rcvd++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            acc = in_valid && in_ready;
            @(posedge aclk);
            #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_total++;
        if (rcvd !== 128) $display("FAIL stream_count: got %0d want 128", rcvd);
        else n_pass++;
        n_total++;
        if (err_last_misalign !== 1'b0)
            $display("FAIL stream_err: got %b want 0", err_last_misalign);
        else n_pass++;
    endtask

    task automatic test_misaligned_last();
        int bad_last = 0;
        do_reset();
        drive_stream(5, -1);
        n_total++;
        if (err_last_misalign !== 1'b0)
            $display("FAIL err_before: got %b want 0", err_last_misalign);
        else n_pass++;
        // Beats 5..63 continue the pixel; in_last on ch 5 and again on ch 63.
        cap_n = 0;
        out_ready = 1'b1;
        for (int c = 5; c < 64 + 6; c++) begin
            in_valid   = (c < 64);
            in_data    = 16'(c);
            multiplier = 32'd256;
            in_last    = (c == 5) || (c == 63);
            @(posedge aclk);
            #1;
            if (out_valid) begin
                if (out_data == 32'd5 && out_last) bad_last++;
                if (out_data == 32'd63) cap_last[0] = out_last;
                cap_n++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_total++;
        if (bad_last !== 0) $display("FAIL misalign_out_last: got %0d want 0", bad_last);
        else n_pass++;
        n_total++;
        if (err_last_misalign !== 1'b1)
            $display("FAIL err_sticky: got %b want 1", err_last_misalign);
        else n_pass++;
        n_total++;
        if (cap_last[0] !== 1'b1)
            $display("FAIL ch63_last_no_resync: got %b want 1", cap_last[0]);
        else n_pass++;
        n_total++;
        if (cap_n !== 59) $display("FAIL misalign_count: got %0d want 59", cap_n);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stream();
        int stale = 0;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid   = 1'b1;
            in_data    = 16'(c + 40);
            multiplier = 32'd256;
            in_last    = 1'b0;
            @(posedge aclk);
            #1;
        end
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1)
            $display("FAIL inflight_before_reset: got %b want 1", out_valid);
        else n_pass++;
        #1 areset = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL reset_async: got %b want 0", out_valid);
        else n_pass++;
        @(posedge aclk);
        @(posedge aclk);
        #1 areset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge aclk);
            #1;
            if (out_valid) stale++;
        end
        n_total++;
        if (stale !== 0) $display("FAIL stale_after_reset: got %0d want 0", stale);
        else n_pass++;
        drive_stream(64, 63);
        n_total++;
        if (cap_n !== 64) $display("FAIL post_reset_count: got %0d want 64", cap_n);
        else n_pass++;
        n_total++;
        if (cap_data[0] !== 32'd0 || cap_data[63] !== 32'd63)
            $display("FAIL post_reset_data: got %0d %0d want 0 63",
                     cap_data[0], cap_data[63]);
        else n_pass++;
        n_total++;
        if (cap_last[63] !== 1'b1 || err_last_misalign !== 1'b0)
            $display("FAIL post_reset_ch0: got last=%b err=%b want 1 0",
                     cap_last[63], err_last_misalign);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_misaligned_last();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
